// File: rtl/frame_reader.sv
// frame_reader: raster-order SRAM frame reader with a 2-entry pixel stream buffer
module frame_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sol,
  output logic                  m_eol,
  output logic                  m_eof
);
  localparam int XW = $clog2(IMG_W + 1);
  localparam int YW = $clog2(IMG_H + 1);
  localparam int EW = DATA_WIDTH + 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t                state;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  inflight;
  logic [2:0]            flags;
  logic [EW-1:0]         b0, b1;
  logic [1:0]            count;
  logic                  pop, issue, last, x_end;
  logic [2:0]            occ;
  // occ is the buffer occupancy after this cycle's pop and the pending return land
  assign pop       = m_valid & m_ready;
  assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue     = (state == RUN) && (occ < 3'd2);
  assign x_end     = x == XW'(IMG_W - 1);
  assign last      = x_end && (y == YW'(IMG_H - 1));
  assign sram_en   = issue;
  assign sram_we   = 1'b0;
  assign sram_addr = addr;
  assign m_valid   = count != 2'd0;
  assign {m_eof, m_eol, m_sol, m_data} = b0;
  // scan control, raster counters and the sideband flags travelling with each read
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      x        <= '0;
      y        <= '0;
      addr     <= '0;
      inflight <= 1'b0;
      flags    <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) flags <= {last, x_end, x == '0};
      if (issue && !last) begin
        x    <= x_end ? '0 : x + XW'(1);
        y    <= x_end ? y + YW'(1) : y;
        addr <= addr + ADDR_WIDTH'(1);
      end
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          x     <= '0;
          y     <= '0;
          addr  <= '0;
        end
        RUN: if (issue && last) state <= DRAIN;
        DRAIN: if (occ == 3'd0) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // two-entry FIFO as a shift pair; the returning word lands behind whatever survives the pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      b0    <= '0;
      b1    <= '0;
    end else begin
      count <= occ[1:0];
      if (pop) b0 <= b1;
      if (inflight && count == {1'b0, pop}) b0 <= {flags, sram_rdata};
      else if (inflight) b1 <= {flags, sram_rdata};
    end
  end
endmodule
